// File: rtl/correlator_pkg.sv
// Shared definitions for the intensity correlator.
//   state_t : correlator control FSM states
//   bin_w() : width of a bin index for a given number of lag bins
package correlator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INTEGRATE = 2'd1,
        ST_SNAP      = 2'd2
    } state_t;

    function automatic int bin_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/correlator_readout.sv
// Shadow frame buffer and streaming readout for the intensity correlator.
// A snapshot request copies all bin counters into the shadow buffer when it
// is empty; otherwise the frame is dropped and the sticky overrun flag set.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   snap               one-cycle snapshot request (FSM in SNAP)
//   snap_data          live bin counters, bin k at index k
//   out_valid/ready    readout handshake
//   out_bin/out_count  index and snapshot count of the current beat
//   out_last           current beat is the final bin
//   overrun            sticky frame-dropped flag
module correlator_readout
    import correlator_pkg::*;
#(
    parameter  int NUM_LAGS = 64,
    parameter  int CNT_W    = 32,
    localparam int BIN_W    = bin_w(NUM_LAGS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               snap,
    input  logic [NUM_LAGS-1:0][CNT_W-1:0]     snap_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [BIN_W-1:0]                   out_bin,
    output logic [CNT_W-1:0]                   out_count,
    output logic                               out_last,
    output logic                               overrun
);

    // Handshake: a beat transfers on any cycle with out_valid & out_ready.
    // While out_valid is high and out_ready low, out_bin/out_count/out_last
    // hold their values. out_valid never drops before the out_last beat.

    logic [NUM_LAGS-1:0][CNT_W-1:0] shadow;
    logic                           full;
    logic [BIN_W-1:0]               idx;
    logic                           beat;
    logic                           last_beat;
    logic                           accept;

    assign beat      = full & out_ready;
    assign last_beat = beat && (idx == BIN_W'(NUM_LAGS - 1));
    // The buffer frees up on the last beat, so a snapshot in that very
    // cycle is still accepted.
    assign accept    = snap && (!full || last_beat);

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            full    <= 1'b0;
            idx     <= '0;
            overrun <= 1'b0;
        end else if (accept) begin
            shadow <= snap_data;
            full   <= 1'b1;
            idx    <= '0;
        end else begin
            if (snap) begin
                overrun <= 1'b1;
            end
            if (beat) begin
                if (last_beat) begin
                    full <= 1'b0;
                    idx  <= '0;
                end else begin
                    idx <= idx + BIN_W'(1);
                end
            end
        end
    end

    assign out_valid = full;
    assign out_bin   = idx;
    assign out_count = shadow[idx];
    assign out_last  = full && (idx == BIN_W'(NUM_LAGS - 1));

endmodule

// File: rtl/intensity_correlator_sync.sv
// Photon intensity correlator: two single-bit detector streams run through
// NUM_LAGS-deep delay lines; bin k counts coincidences of line1[k] with
// line2[NUM_LAGS-1-k] over a programmable window. The finished frame is
// handed to a double-buffered readout while the next window accumulates.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   in1, in2               synchronised detector pulses
//   auto_mode              1: in1 feeds both delay lines
//   win_len                window length in cycles (0 behaves as 1), latched on start
//   start, abort           begin a window from IDLE / discard the current window
//   continuous             restart a window automatically after each SNAP
//   busy                   window integrating or being snapshotted
//   out_valid/out_ready    readout handshake; out_bin/out_count/out_last beat data
//   overrun                sticky: a finished frame was dropped
module intensity_correlator_sync
    import correlator_pkg::*;
#(
    parameter  int NUM_LAGS  = 64,
    parameter  int CNT_W     = 32,
    parameter  int WIN_W     = 32,
    parameter  int EDGE_MODE = 1,
    localparam int BIN_W     = bin_w(NUM_LAGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in1,
    input  logic              in2,
    input  logic              auto_mode,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  out_bin,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              overrun
);

    state_t                         state;
    state_t                         state_nxt;
    logic [NUM_LAGS-1:0]            line1;
    logic [NUM_LAGS-1:0]            line2;
    logic [NUM_LAGS-1:0]            coinc;
    logic [NUM_LAGS-1:0]            inc;
    logic [NUM_LAGS-1:0][CNT_W-1:0] cnt;
    logic [WIN_W-1:0]               win_len_q;
    logic [WIN_W-1:0]               win_cnt;
    logic                           win_start;
    logic                           snap;
    logic                           clr_cnt;

    // Delay lines keep shifting in every state; only counting is gated.
    always_ff @(posedge clk) begin
        if (reset) begin
            line1 <= '0;
            line2 <= '0;
        end else begin
            line1 <= {line1[NUM_LAGS-2:0], in1};
            line2 <= {line2[NUM_LAGS-2:0], (auto_mode ? in1 : in2)};
        end
    end

    always_comb begin
        coinc = '0;
        for (int k = 0; k < NUM_LAGS; k++) begin
            coinc[k] = line1[k] & line2[NUM_LAGS-1-k];
        end
    end

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [NUM_LAGS-1:0] coinc_q;
            // Cleared at window start so a coincidence already high counts once.
            always_ff @(posedge clk) begin
                if (reset || win_start) begin
                    coinc_q <= '0;
                end else begin
                    coinc_q <= coinc;
                end
            end
            assign inc = coinc & ~coinc_q;
        end else begin : g_level
            assign inc = coinc;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        win_start = 1'b0;
        snap      = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_INTEGRATE;
                    win_start = 1'b1;
                end
            end
            ST_INTEGRATE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    clr_cnt   = 1'b1;
                end else if (win_cnt == win_len_q - WIN_W'(1)) begin
                    state_nxt = ST_SNAP;
                end
            end
            ST_SNAP: begin
                snap    = 1'b1;
                clr_cnt = 1'b1;
                if (continuous) begin
                    state_nxt = ST_INTEGRATE;
                    win_start = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            win_cnt   <= '0;
            win_len_q <= WIN_W'(1);
        end else begin
            state <= state_nxt;
            if (win_start) begin
                win_cnt <= '0;
            end else if (state == ST_INTEGRATE) begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
            // A continuous restart reuses the length latched by the original start.
            if (state == ST_IDLE && win_start) begin
                win_len_q <= (win_len == '0) ? WIN_W'(1) : win_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            cnt <= '0;
        end else if (state == ST_INTEGRATE) begin
            for (int k = 0; k < NUM_LAGS; k++) begin
                if (inc[k] && (cnt[k] != '1)) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

    correlator_readout #(
        .NUM_LAGS (NUM_LAGS),
        .CNT_W    (CNT_W)
    ) u_readout (
        .clk       (clk),
        .reset     (reset),
        .snap      (snap),
        .snap_data (cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_count (out_count),
        .out_last  (out_last),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_intensity_correlator_sync.sv
module tb_intensity_correlator_sync;

    localparam int NUM_LAGS = 8;
    localparam int CNT_W    = 4;
    localparam int WIN_W    = 16;
    localparam int BIN_W    = 3;
    localparam int HIST     = 16384;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct {
        string       name;
        logic        auto_m;
        logic        pre;     // both inputs high for the 10 cycles before start
        logic [63:0] p1;      // bit i: in1 high on the cycle sampled i edges after start
        logic [63:0] p2;
        int          win;
        logic [31:0] exp_e;   // expected frame, edge-mode instance (bin k in bits 4k+3:4k)
        logic [31:0] exp_l;   // expected frame, level-mode instance
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             in1, in2, auto_mode, start, abort, continuous, out_ready;
    logic [WIN_W-1:0] win_len;

    logic             e_busy, e_valid, e_last, e_overrun;
    logic [BIN_W-1:0] e_bin;
    logic [CNT_W-1:0] e_count;
    logic             l_busy, l_valid, l_last, l_overrun;
    logic [BIN_W-1:0] l_bin;
    logic [CNT_W-1:0] l_count;

    intensity_correlator_sync #(
        .NUM_LAGS(NUM_LAGS), .CNT_W(CNT_W), .WIN_W(WIN_W), .EDGE_MODE(1)
    ) u_edge (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .auto_mode(auto_mode),
        .win_len(win_len), .start(start), .abort(abort), .continuous(continuous),
        .busy(e_busy), .out_valid(e_valid), .out_ready(out_ready), .out_bin(e_bin),
        .out_count(e_count), .out_last(e_last), .overrun(e_overrun)
    );

    intensity_correlator_sync #(
        .NUM_LAGS(NUM_LAGS), .CNT_W(CNT_W), .WIN_W(WIN_W), .EDGE_MODE(0)
    ) u_lvl (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .auto_mode(auto_mode),
        .win_len(win_len), .start(start), .abort(abort), .continuous(continuous),
        .busy(l_busy), .out_valid(l_valid), .out_ready(out_ready), .out_bin(l_bin),
        .out_count(l_count), .out_last(l_last), .overrun(l_overrun)
    );

    // ---------------- input history for the reference model ----------------
    // h1/h2[n] hold the detector values sampled at clock edge n (0 during reset).
    bit h1 [HIST];
    bit h2 [HIST];
    int cyc = 0;

    always @(posedge clk) begin
        if (cyc + 1 < HIST) begin
            h1[cyc+1] <= reset ? 1'b0 : in1;
            h2[cyc+1] <= reset ? 1'b0 : (auto_mode ? in1 : in2);
        end
        cyc <= cyc + 1;
    end

    function automatic bit hv1(input int i);
        return (i < 0 || i >= HIST) ? 1'b0 : h1[i];
    endfunction

    function automatic bit hv2(input int i);
        return (i < 0 || i >= HIST) ? 1'b0 : h2[i];
    endfunction

    // ---------------- scoreboard ----------------
    logic [CNT_W-1:0] exp_e_q[$];
    logic [CNT_W-1:0] exp_l_q[$];
    int checks = 0;
    int errors = 0;
    bit rand_in = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window started at edge s lasting len cycles: bin k sees in1 delayed k
    // cycles against in2 delayed NUM_LAGS-1-k cycles, at each edge m in the window.
    task automatic model_push(input int s, input int len);
        for (int k = 0; k < NUM_LAGS; k++) begin
            int ce = 0;
            int cl = 0;
            bit prev = 0;
            for (int m = s; m < s + len; m++) begin
                bit c;
                c = hv1(m - k) & hv2(m - (NUM_LAGS - 1) + k);
                if (c && cl < CNT_MAX) cl++;
                if (c && !prev && ce < CNT_MAX) ce++;
                prev = c;
            end
            exp_e_q.push_back(cnt_t'(ce));
            exp_l_q.push_back(cnt_t'(cl));
        end
    endtask

    task automatic push_const(input logic [31:0] fe, input logic [31:0] fl);
        for (int k = 0; k < NUM_LAGS; k++) begin
            exp_e_q.push_back(fe[4*k +: 4]);
            exp_l_q.push_back(fl[4*k +: 4]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_in) begin
            in1 = 1'($urandom_range(0, 1));
            in2 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic read_frame(input int nbeats, input int budget);
        int got = 0;
        int waited = 0;
        bit fire;
        while (got < nbeats && waited < budget) begin
            if (e_valid || l_valid) begin
                chk("valid_match", l_valid, e_valid);
                if (exp_e_q.size() > 0) begin
                    chk("bin_e", e_bin, got);
                    chk("bin_l", l_bin, got);
                    chk("count_e", e_count, exp_e_q[0]);
                    chk("count_l", l_count, exp_l_q[0]);
                    chk("last_e", e_last, (got == NUM_LAGS - 1));
                    chk("last_l", l_last, (got == NUM_LAGS - 1));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            fire = e_valid && out_ready;
            step();
            waited++;
            if (fire) begin
                void'(exp_e_q.pop_front());
                void'(exp_l_q.pop_front());
                got++;
            end
        end
        chk("readout_beats", got, nbeats);
        out_ready = 1'b0;
        if (nbeats == NUM_LAGS) begin
            chk("valid_after_last_e", e_valid, 0);
            chk("valid_after_last_l", l_valid, 0);
        end
    endtask

    task automatic run_vec(input vec_t v, input int nbeats);
        int leff;
        rand_in   = 0;
        auto_mode = v.auto_m;
        win_len   = WIN_W'(v.win);
        leff      = (v.win == 0) ? 1 : v.win;
        for (int i = -10; i <= leff + 2; i++) begin
            if (i < 0) begin
                in1 = v.pre;
                in2 = v.pre;
            end else begin
                in1 = (i < 64) ? v.p1[i] : 1'b0;
                in2 = (i < 64) ? v.p2[i] : 1'b0;
            end
            start = (i == 0);
            step();
            if (i == 0) begin
                chk({v.name, "_busy"}, e_busy, 1);
            end
        end
        start = 1'b0;
        in1   = 1'b0;
        in2   = 1'b0;
        push_const(v.exp_e, v.exp_l);
        read_frame(nbeats, 200);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    vec_t vecs[6];

    initial begin
        vecs[0] = '{"xpulse",     1'b0, 1'b0, 64'h4,  64'h20, 20, 32'h0010_0000, 32'h0010_0000};
        vecs[1] = '{"hold_sat",   1'b0, 1'b1, '1,     '1,     40, 32'h1111_1111, 32'hFFFF_FFFF};
        vecs[2] = '{"auto_pair",  1'b1, 1'b0, 64'h24, '1,     20, 32'h0010_0100, 32'h0010_0100};
        vecs[3] = '{"win_zero",   1'b0, 1'b1, '1,     '1,      0, 32'h1111_1111, 32'h1111_1111};
        vecs[4] = '{"cross_rev",  1'b0, 1'b0, 64'h40, 64'h2,  20, 32'h0000_0010, 32'h0000_0010};
        vecs[5] = '{"level_run",  1'b0, 1'b0, 64'h7,  64'h7,  20, 32'h0001_1000, 32'h0002_2000};

        in1 = 0; in2 = 0; auto_mode = 0; start = 0; abort = 0;
        continuous = 0; out_ready = 0; win_len = '0;

        // Reset state
        reset = 1'b1;
        repeat (10) step();
        chk("rst_busy",    e_busy | l_busy, 0);
        chk("rst_valid",   e_valid | l_valid, 0);
        chk("rst_bin",     e_bin | l_bin, 0);
        chk("rst_count",   e_count | l_count, 0);
        chk("rst_last",    e_last | l_last, 0);
        chk("rst_overrun", e_overrun | l_overrun, 0);
        reset = 1'b0;
        step();

        // Table-driven directed frames
        foreach (vecs[i]) run_vec(vecs[i], NUM_LAGS);

        // Reset in the middle of a readout
        run_vec(vecs[3], 3);
        reset = 1'b1;
        step();
        chk("midrst_valid_e",   e_valid, 0);
        chk("midrst_valid_l",   l_valid, 0);
        chk("midrst_overrun",   e_overrun | l_overrun, 0);
        chk("midrst_busy",      e_busy | l_busy, 0);
        chk("midrst_bin",       e_bin, 0);
        repeat (9) step();
        reset = 1'b0;
        exp_e_q.delete();
        exp_l_q.delete();
        run_vec(vecs[0], NUM_LAGS);

        // Continuous windows with stalled readout: second frame overruns
        auto_mode = 0; in1 = 1; in2 = 1;
        repeat (10) step();
        continuous = 1; win_len = 4; out_ready = 0;
        start = 1;
        step();
        start = 0;
        repeat (5) step();
        chk("ovr_first_valid", e_valid & l_valid, 1);
        chk("ovr_not_yet",     e_overrun | l_overrun, 0);
        repeat (5) step();
        chk("ovr_set_e", e_overrun, 1);
        chk("ovr_set_l", l_overrun, 1);
        continuous = 0;
        begin
            int w = 0;
            while ((e_busy || l_busy) && w < 50) begin
                step();
                w++;
            end
            chk("ovr_idle_timeout", (w < 50), 1);
        end
        in1 = 0; in2 = 0;
        chk("ovr_held_bin", e_bin, 0);
        push_const(32'h1111_1111, 32'h4444_4444);
        read_frame(NUM_LAGS, 200);
        chk("ovr_sticky", e_overrun & l_overrun, 1);
        do_reset(10);
        chk("ovr_cleared", e_overrun | l_overrun, 0);

        // Abort at cycle 2 of a 10-cycle window; abort beats start in IDLE
        in1 = 1; in2 = 1;
        repeat (10) step();
        win_len = 10;
        start = 1;
        step();
        start = 0;
        step();
        abort = 1;
        step();
        abort = 0;
        chk("abort_busy_e", e_busy, 0);
        chk("abort_busy_l", l_busy, 0);
        begin
            bit saw = 0;
            repeat (15) begin
                step();
                if (e_valid || l_valid) saw = 1;
            end
            chk("abort_no_frame", saw, 0);
        end
        abort = 1; start = 1;
        step();
        abort = 0; start = 0;
        chk("abort_wins_start", e_busy | l_busy, 0);
        win_len = 5;
        start = 1;
        step();
        start = 0;
        repeat (5) step();
        push_const(32'h1111_1111, 32'h5555_5555);
        read_frame(NUM_LAGS, 200);

        // Randomized windows against the reference model
        rand_in = 1;
        for (int n = 0; n < 14; n++) begin
            int L;
            int leff;
            int s;
            auto_mode = 1'($urandom_range(0, 1));
            L = $urandom_range(0, 24);
            leff = (L == 0) ? 1 : L;
            win_len = WIN_W'(L);
            start = 1;
            step();
            s = cyc;
            start = 0;
            for (int j = 0; j < leff; j++) begin
                start = ($urandom_range(0, 4) == 0);  // ignored while busy
                step();
            end
            start = 0;
            model_push(s, leff);
            read_frame(NUM_LAGS, 300);
        end
        rand_in = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
